// File: rtl/sfm_batch_ctrl.sv
// Multi-row softmax sequencer: per row runs accumulate pass, reciprocal wait and divide pass,
// driving the in/out streamers and datapath strobes, then steps both addresses by the row stride.
//
// state     | meaning
// IDLE      | waiting for start_i, cfg latched on start
// ROW_START | kick input streamer for the accumulate pass
// ACCUM     | accumulate pass streaming in
// WAIT_DP   | draining datapath pipeline
// WAIT_ACC  | waiting for denominator, then restart input and start output
// WAIT_INV  | waiting for reciprocal, early out_done remembered
// DIVIDE    | divide pass streaming out
// ROW_END   | row finished, advance addresses / row index
// FINISHED  | job done pulse
module sfm_batch_ctrl #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 32,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    cfg_in_addr_i,
  input  logic [ADDR_WIDTH-1:0]    cfg_out_addr_i,
  input  logic [LEN_WIDTH-1:0]     cfg_row_len_i,
  input  logic [ADDR_WIDTH-1:0]    cfg_row_stride_i,
  input  logic [ROW_CNT_WIDTH-1:0] cfg_n_rows_i,
  output logic                     in_start_o,
  output logic [ADDR_WIDTH-1:0]    in_addr_o,
  output logic [LEN_WIDTH-1:0]     in_tot_len_o,
  input  logic                     in_done_i,
  output logic                     out_start_o,
  output logic [ADDR_WIDTH-1:0]    out_addr_o,
  output logic [LEN_WIDTH-1:0]     out_tot_len_o,
  input  logic                     out_done_i,
  input  logic                     dp_busy_i,
  input  logic                     acc_done_i,
  input  logic                     inv_done_i,
  output logic                     dp_acc_finished_o,
  output logic                     dp_dividing_o,
  output logic                     dp_disable_max_o,
  output logic                     dp_clear_regs_o,
  output logic                     busy_o,
  output logic                     row_done_o,
  output logic [ROW_CNT_WIDTH-1:0] row_idx_o,
  output logic                     done_o
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BPW);

  typedef enum logic [3:0] {
    IDLE, ROW_START, ACCUM, WAIT_DP, WAIT_ACC, WAIT_INV, DIVIDE, ROW_END, FINISHED
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]    in_addr_q, out_addr_q, stride_q;
  logic [LEN_WIDTH-1:0]     tot_len_q;
  logic [ROW_CNT_WIDTH-1:0] n_rows_q, row_idx_q;
  logic                     out_seen_q;
  logic [LEN_WIDTH-1:0]     len_rem, len_words;
  logic                     last_row, empty_job;

  assign len_rem   = cfg_row_len_i & LEN_WIDTH'(BPW - 1);
  assign len_words = (cfg_row_len_i >> SHIFT) + LEN_WIDTH'(len_rem != '0);
  assign empty_job = (cfg_n_rows_i == '0) || (cfg_row_len_i == '0);
  assign last_row  = (row_idx_q == n_rows_q - ROW_CNT_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_i) state_d = empty_job ? FINISHED : ROW_START;
      ROW_START: state_d = ACCUM;
      ACCUM:     if (in_done_i) state_d = WAIT_DP;
      WAIT_DP:   if (!dp_busy_i) state_d = WAIT_ACC;
      WAIT_ACC:  if (acc_done_i) state_d = WAIT_INV;
      WAIT_INV:  if (inv_done_i) state_d = DIVIDE;
      DIVIDE:    if (out_done_i || out_seen_q) state_d = ROW_END;
      ROW_END:   state_d = last_row ? FINISHED : ROW_START;
      FINISHED:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    in_start_o        = 1'b0;
    out_start_o       = 1'b0;
    dp_acc_finished_o = 1'b0;
    dp_dividing_o     = 1'b0;
    dp_disable_max_o  = 1'b0;
    dp_clear_regs_o   = 1'b0;
    row_done_o        = 1'b0;
    done_o            = 1'b0;
    busy_o            = (state_q != IDLE) && (state_q != FINISHED);
    unique case (state_q)
      ROW_START: in_start_o = 1'b1;
      WAIT_DP:   dp_acc_finished_o = !dp_busy_i;
      WAIT_ACC: begin
        dp_disable_max_o  = 1'b1;
        dp_acc_finished_o = !acc_done_i;
        in_start_o        = acc_done_i;
        out_start_o       = acc_done_i;
      end
      WAIT_INV, DIVIDE: begin
        dp_dividing_o    = 1'b1;
        dp_disable_max_o = 1'b1;
      end
      ROW_END: begin
        dp_clear_regs_o = 1'b1;
        row_done_o      = 1'b1;
      end
      FINISHED: done_o = 1'b1;
      default: ;
    endcase
  end

  // Addresses and lengths stay registered so the streamers see stable values for the whole row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_addr_q  <= '0;
      out_addr_q <= '0;
      stride_q   <= '0;
      tot_len_q  <= '0;
      n_rows_q   <= '0;
      row_idx_q  <= '0;
      out_seen_q <= 1'b0;
    end else if (clear_i) begin
      in_addr_q  <= '0;
      out_addr_q <= '0;
      stride_q   <= '0;
      tot_len_q  <= '0;
      n_rows_q   <= '0;
      row_idx_q  <= '0;
      out_seen_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          in_addr_q  <= cfg_in_addr_i;
          out_addr_q <= cfg_out_addr_i;
          stride_q   <= cfg_row_stride_i;
          tot_len_q  <= len_words;
          n_rows_q   <= cfg_n_rows_i;
          row_idx_q  <= '0;
        end
        WAIT_INV: if (out_done_i) out_seen_q <= 1'b1;
        ROW_END: begin
          out_seen_q <= 1'b0;
          in_addr_q  <= in_addr_q + stride_q;
          out_addr_q <= out_addr_q + stride_q;
          if (!last_row) row_idx_q <= row_idx_q + ROW_CNT_WIDTH'(1);
        end
        FINISHED: begin
          in_addr_q  <= '0;
          out_addr_q <= '0;
          row_idx_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_addr_o     = in_addr_q;
  assign out_addr_o    = out_addr_q;
  assign in_tot_len_o  = tot_len_q;
  assign out_tot_len_o = tot_len_q;
  assign row_idx_o     = row_idx_q;

endmodule

// File: tb/tb_sfm_batch_ctrl.sv
// Bench for sfm_batch_ctrl: a scripted row-by-row job model plays the streamers/datapath with random
// delays and noise, sets the expected outputs of every cycle, and a negedge process compares them.
module tb_sfm_batch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, start_i;
  logic [31:0] cfg_in_addr_i, cfg_out_addr_i, cfg_row_len_i, cfg_row_stride_i;
  logic [15:0] cfg_n_rows_i;
  logic        in_start_o, out_start_o, in_done_i, out_done_i;
  logic [31:0] in_addr_o, out_addr_o, in_tot_len_o, out_tot_len_o;
  logic        dp_busy_i, acc_done_i, inv_done_i;
  logic        dp_acc_finished_o, dp_dividing_o, dp_disable_max_o, dp_clear_regs_o;
  logic        busy_o, row_done_o, done_o;
  logic [15:0] row_idx_o;

  sfm_batch_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .cfg_in_addr_i(cfg_in_addr_i), .cfg_out_addr_i(cfg_out_addr_i),
    .cfg_row_len_i(cfg_row_len_i), .cfg_row_stride_i(cfg_row_stride_i),
    .cfg_n_rows_i(cfg_n_rows_i),
    .in_start_o(in_start_o), .in_addr_o(in_addr_o), .in_tot_len_o(in_tot_len_o),
    .in_done_i(in_done_i),
    .out_start_o(out_start_o), .out_addr_o(out_addr_o), .out_tot_len_o(out_tot_len_o),
    .out_done_i(out_done_i),
    .dp_busy_i(dp_busy_i), .acc_done_i(acc_done_i), .inv_done_i(inv_done_i),
    .dp_acc_finished_o(dp_acc_finished_o), .dp_dividing_o(dp_dividing_o),
    .dp_disable_max_o(dp_disable_max_o), .dp_clear_regs_o(dp_clear_regs_o),
    .busy_o(busy_o), .row_done_o(row_done_o), .row_idx_o(row_idx_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int n_row_done = 0;
  int n_done = 0;
  logic [31:0] cap_in[$];
  logic [31:0] cap_len[$];

  // expected values for the current cycle
  logic        e_is, e_os, e_af, e_dv, e_dm, e_cr, e_bz, e_rd, e_dn;
  logic [15:0] e_idx;
  logic [31:0] e_in_addr, e_out_addr, e_len;
  logic        chk_idx, chk_addr, chk_len, noise_ok;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    cmp("in_start", 32'(in_start_o), 32'(e_is));
    cmp("out_start", 32'(out_start_o), 32'(e_os));
    cmp("acc_finished", 32'(dp_acc_finished_o), 32'(e_af));
    cmp("dividing", 32'(dp_dividing_o), 32'(e_dv));
    cmp("disable_max", 32'(dp_disable_max_o), 32'(e_dm));
    cmp("clear_regs", 32'(dp_clear_regs_o), 32'(e_cr));
    cmp("busy", 32'(busy_o), 32'(e_bz));
    cmp("row_done", 32'(row_done_o), 32'(e_rd));
    cmp("done", 32'(done_o), 32'(e_dn));
    if (chk_idx) cmp("row_idx", 32'(row_idx_o), 32'(e_idx));
    if (chk_addr) begin
      cmp("in_addr", in_addr_o, e_in_addr);
      cmp("out_addr", out_addr_o, e_out_addr);
    end
    if (chk_len) begin
      cmp("in_tot_len", in_tot_len_o, e_len);
      cmp("out_tot_len", out_tot_len_o, e_len);
    end
    if (row_done_o) n_row_done++;
    if (done_o) n_done++;
    if (in_start_o && !out_start_o) begin
      cap_in.push_back(in_addr_o);
      cap_len.push_back(in_tot_len_o);
    end
  end

  task automatic ex(input logic is, os, af, dv, dm, cr, bz, rd, dn);
    e_is = is; e_os = os; e_af = af; e_dv = dv; e_dm = dm;
    e_cr = cr; e_bz = bz; e_rd = rd; e_dn = dn;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
    start_i = 0; clear_i = 0; in_done_i = 0; out_done_i = 0;
    dp_busy_i = 0; acc_done_i = 0; inv_done_i = 0;
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (noise_ok) begin
      start_i          = 1'($urandom_range(0, 1));
      cfg_in_addr_i    = $urandom;
      cfg_out_addr_i   = $urandom;
      cfg_row_len_i    = $urandom;
      cfg_row_stride_i = $urandom;
      cfg_n_rows_i     = 16'($urandom);
    end
  endtask

  function automatic logic [31:0] qget(input int i);
    return (i < cap_in.size()) ? cap_in[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lget(input int i);
    return (i < cap_len.size()) ? cap_len[i] : 32'hDEAD_BEEF;
  endfunction

  // mode: 0 random, 1 out_done early (during reciprocal wait), 2 out_done late
  task automatic run_job(input logic [31:0] in_b, out_b, len, stride, input int n,
                         input int mode, input bit clr);
    logic [31:0] words;
    bit          early;
    int          k, pos, ni;
    words = len / 32'd16 + ((len % 32'd16) != 0 ? 32'd1 : 32'd0);
    nxt();
    start_i = 1; cfg_in_addr_i = in_b; cfg_out_addr_i = out_b; cfg_row_len_i = len;
    cfg_row_stride_i = stride; cfg_n_rows_i = 16'(n);
    chk_idx = 1; e_idx = 0; chk_addr = 1; e_in_addr = 0; e_out_addr = 0;
    noise_ok = 1;
    if (n == 0 || len == 0) begin
      nxt(); ex(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_idx = 0; chk_addr = 0; chk_len = 1; e_len = words;
    end else begin
      for (int r = 0; r < n; r++) begin
        nxt(); ex(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk_len = 1; e_len = words; chk_idx = 1; e_idx = 16'(r); chk_addr = 1;
        e_in_addr = in_b + 32'(r) * stride; e_out_addr = out_b + 32'(r) * stride;
        k = $urandom_range(0, 3);
        for (int q = 0; q <= k; q++) begin
          nxt(); ex(0, 0, 0, 0, 0, 0, 1, 0, 0);
          dp_busy_i = 1'($urandom_range(0, 1)); acc_done_i = 1'($urandom_range(0, 1));
          inv_done_i = 1'($urandom_range(0, 1)); in_done_i = (q == k);
        end
        k = $urandom_range(0, 3);
        for (int q = 0; q < k; q++) begin
          nxt(); ex(0, 0, 0, 0, 0, 0, 1, 0, 0);
          dp_busy_i = 1; in_done_i = 1'($urandom_range(0, 1));
          acc_done_i = 1'($urandom_range(0, 1)); inv_done_i = 1'($urandom_range(0, 1));
        end
        nxt(); ex(0, 0, 1, 0, 0, 0, 1, 0, 0);
        k = $urandom_range(0, 3);
        for (int q = 0; q < k; q++) begin
          nxt(); ex(0, 0, 1, 0, 1, 0, 1, 0, 0);
          dp_busy_i = 1'($urandom_range(0, 1)); inv_done_i = 1'($urandom_range(0, 1));
        end
        nxt(); ex(1, 1, 0, 0, 1, 0, 1, 0, 0); acc_done_i = 1;
        early = (mode == 1) || (mode == 0 && $urandom_range(0, 1) == 1);
        ni = $urandom_range(0, 3);
        pos = $urandom_range(0, ni);
        for (int q = 0; q <= ni; q++) begin
          nxt(); ex(0, 0, 0, 1, 1, 0, 1, 0, 0);
          inv_done_i = (q == ni); out_done_i = early && (q == pos);
          in_done_i = 1'($urandom_range(0, 1)); acc_done_i = 1'($urandom_range(0, 1));
        end
        if (!early) begin
          k = $urandom_range(0, 3);
          for (int q = 0; q < k; q++) begin
            nxt(); ex(0, 0, 0, 1, 1, 0, 1, 0, 0);
            in_done_i = 1'($urandom_range(0, 1)); dp_busy_i = 1'($urandom_range(0, 1));
          end
        end
        nxt(); ex(0, 0, 0, 1, 1, 0, 1, 0, 0);
        in_done_i = 1'($urandom_range(0, 1));
        if (clr) begin
          clear_i = 1;
          noise_ok = 0;
          nxt(); ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
          e_idx = 0; e_in_addr = 0; e_out_addr = 0; e_len = 0;
          return;
        end
        if (!early) out_done_i = 1;
        nxt(); ex(0, 0, 1'b0, 0, 0, 1, 1, 1, 0);
      end
      nxt(); ex(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_idx = 0; chk_addr = 0;
    end
    noise_ok = 0;
    nxt(); ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_idx = 1; e_idx = 0; chk_addr = 1; e_in_addr = 0; e_out_addr = 0;
  endtask

  int rd0, dn0;

  task automatic mark();
    rd0 = n_row_done; dn0 = n_done;
    cap_in.delete(); cap_len.delete();
  endtask

  initial begin
    rst_ni = 0; clear_i = 0; start_i = 0; in_done_i = 0; out_done_i = 0;
    dp_busy_i = 0; acc_done_i = 0; inv_done_i = 0;
    cfg_in_addr_i = 0; cfg_out_addr_i = 0; cfg_row_len_i = 0; cfg_row_stride_i = 0;
    cfg_n_rows_i = 0;
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_idx = 0; e_in_addr = 0; e_out_addr = 0; e_len = 0;
    chk_idx = 1; chk_addr = 1; chk_len = 1; noise_ok = 0;
    #22 rst_ni = 1;
    nxt(); nxt();

    mark(); run_job(32'h1000, 32'h2000, 64, 32'h40, 1, 0, 0);
    cmp("len64_words", lget(0), 32'd4);
    cmp("len64_in_addr", qget(0), 32'h1000);
    cmp("len64_row_dones", 32'(n_row_done - rd0), 32'd1);
    cmp("len64_dones", 32'(n_done - dn0), 32'd1);

    mark(); run_job(32'h3000, 32'h4000, 70, 32'h80, 1, 2, 0);
    cmp("len70_words", lget(0), 32'd5);
    mark(); run_job(32'h3000, 32'h4000, 16, 32'h80, 1, 1, 0);
    cmp("len16_words", lget(0), 32'd1);

    mark(); run_job(32'h5000, 32'h6000, 0, 32'h80, 2, 0, 0);
    cmp("len0_in_starts", 32'(cap_in.size()), 32'd0);
    cmp("len0_dones", 32'(n_done - dn0), 32'd1);

    mark(); run_job(32'h1000, 32'h2000, 48, 32'h100, 3, 0, 0);
    cmp("rows3_addr0", qget(0), 32'h1000);
    cmp("rows3_addr1", qget(1), 32'h1100);
    cmp("rows3_addr2", qget(2), 32'h1200);
    cmp("rows3_row_dones", 32'(n_row_done - rd0), 32'd3);
    cmp("rows3_dones", 32'(n_done - dn0), 32'd1);

    mark(); run_job(32'h1000, 32'h2000, 64, 32'h100, 0, 0, 0);
    cmp("nrows0_in_starts", 32'(cap_in.size()), 32'd0);
    cmp("nrows0_dones", 32'(n_done - dn0), 32'd1);

    mark(); run_job(32'h7000, 32'h8000, 32, 32'h20, 2, 1, 0);
    cmp("early_out_row_dones", 32'(n_row_done - rd0), 32'd2);

    mark(); run_job(32'h7000, 32'h8000, 32, 32'h20, 2, 0, 1);
    cmp("clear_row_dones", 32'(n_row_done - rd0), 32'd0);
    cmp("clear_dones", 32'(n_done - dn0), 32'd0);
    mark(); run_job(32'h9000, 32'hA000, 33, 32'h20, 1, 0, 0);
    cmp("restart_words", lget(0), 32'd3);
    cmp("restart_dones", 32'(n_done - dn0), 32'd1);

    mark(); run_job(32'hFFFF_FF00, 32'h0000_1000, 64, 32'h100, 2, 0, 0);
    cmp("wrap_addr0", qget(0), 32'hFFFF_FF00);
    cmp("wrap_addr1", qget(1), 32'h0000_0000);

    for (int j = 0; j < 40; j++) begin
      run_job($urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 400)),
              $urandom, $urandom_range(0, 3), 0, 0);
    end

    nxt();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
